// File: rtl/param_synch_fifo.sv
// Single-clock FIFO, arbitrary DEPTH, with level flags, fill count, sticky errors and flush.
// Latency: write visible next cycle; standard read data 1 cycle after read_en; FWFT presents head combinationally.
// Backpressure: writes dropped when full (overflow sets), reads ignored when empty (underflow sets).
// Build option: define PARAM_SYNCH_FIFO_FWFT_EN for first-word-fall-through output.
module param_synch_fifo #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 5,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             clear_errors,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             dout_valid,
  output logic [CNT_W-1:0] fill_count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    write_addr;
  logic [AW-1:0]    read_addr;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_set;
  logic             udf_set;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Status flags derive from the registered count only.
  assign empty        = (fill_count == '0);
  assign full         = (fill_count == CNT_W'(DEPTH));
  assign almost_full  = (int'(fill_count) >= AFULL_THRESH);
  assign almost_empty = (int'(fill_count) <= AEMPTY_THRESH);

  // Acceptance uses start-of-cycle state; flush masks both requests.
  assign wr_acc  = write_en && !full && !flush;
  assign rd_acc  = read_en && !empty && !flush;
  assign ovf_set = write_en && full && !flush;
  assign udf_set = read_en && empty && !flush;

  // Storage array; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[write_addr] <= data_in;
    end
  end

  // Pointer and fill-count bookkeeping; flush has top priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_addr <= '0;
      read_addr  <= '0;
      fill_count <= '0;
    end else if (flush) begin
      write_addr <= '0;
      read_addr  <= '0;
      fill_count <= '0;
    end else begin
      if (wr_acc) write_addr <= next_addr(write_addr);
      if (rd_acc) read_addr  <= next_addr(read_addr);
      case ({wr_acc, rd_acc})
        2'b10:   fill_count <= fill_count + CNT_W'(1);
        2'b01:   fill_count <= fill_count - CNT_W'(1);
        default: fill_count <= fill_count;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_errors) || ovf_set;
      underflow <= (underflow && !clear_errors) || udf_set;
    end
  end

`ifdef PARAM_SYNCH_FIFO_FWFT_EN
  // Head of queue is always presented; valid whenever something is stored.
  assign data_out   = mem[read_addr];
  assign dout_valid = !empty;
`else
  // Registered read port: data follows an accepted read by one cycle and holds otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[read_addr];
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_synch_fifo.sv
// Testbench for param_synch_fifo (DEPTH=5, AFULL=4, AEMPTY=1): table vectors, corner sequences, random vs queue model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Works in both the registered and the FWFT build.
module tb_param_synch_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             clear_errors = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             write_en = 1'b0;
  logic             read_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             dout_valid;
  logic [CNT_W-1:0] fill_count;
  logic             empty, full, almost_empty, almost_full, overflow, underflow;

  param_synch_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clear_errors(clear_errors),
    .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .data_out(data_out), .dout_valid(dout_valid), .fill_count(fill_count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a queue plus error bits and the registered read port.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0, m_udf = 1'b0, m_vld = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dout = '0;
  endtask

  task automatic model_step(input logic fl, input logic cl, input logic wr, input logic rd,
                            input logic [WIDTH-1:0] d);
    int  n;
    bit  oset, uset;
    n = mq.size();
    oset = 0; uset = 0;
    if (fl) begin
      mq.delete();
      m_vld = 1'b0;
    end else begin
      oset = wr && (n == DEPTH);
      uset = rd && (n == 0);
      m_vld = 1'b0;
      if (rd && n > 0) begin
        m_dout = mq.pop_front();
        m_vld  = 1'b1;
      end
      if (wr && n < DEPTH) mq.push_back(d);
    end
    m_ovf = cl ? oset : (m_ovf | oset);
    m_udf = cl ? uset : (m_udf | uset);
  endtask

  task automatic check_level(input string tag, input int cnt);
    chk({tag, ".count"}, 64'(fill_count), 64'(cnt));
    chk({tag, ".empty"}, 64'(empty), 64'(cnt == 0));
    chk({tag, ".full"}, 64'(full), 64'(cnt == DEPTH));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(cnt <= 1));
    chk({tag, ".afull"}, 64'(almost_full), 64'(cnt >= 4));
  endtask

  task automatic check_model(input string tag);
    check_level(tag, mq.size());
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(underflow), 64'(m_udf));
`ifdef PARAM_SYNCH_FIFO_FWFT_EN
    chk({tag, ".vld"}, 64'(dout_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".dout"}, data_out, mq[0]);
`else
    chk({tag, ".vld"}, 64'(dout_valid), 64'(m_vld));
    chk({tag, ".dout"}, data_out, m_dout);
`endif
  endtask

  task automatic drive(input logic fl, input logic cl, input logic wr, input logic rd,
                       input logic [WIDTH-1:0] d);
    flush = fl; clear_errors = cl; write_en = wr; read_en = rd; data_in = d;
    @(posedge clock);
    model_step(fl, cl, wr, rd, d);
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check_level(tag, 0);
    chk({tag, ".ovf"}, 64'(overflow), 64'd0);
    chk({tag, ".udf"}, 64'(underflow), 64'd0);
    chk({tag, ".vld"}, 64'(dout_valid), 64'd0);
`ifndef PARAM_SYNCH_FIFO_FWFT_EN
    chk({tag, ".dout"}, data_out, 64'd0);
`endif
  endtask

  task automatic do_reset();
    flush = 0; clear_errors = 0; write_en = 0; read_en = 0; data_in = '0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic             fl, cl, wr, rd;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic             ovf, udf, vld;
    logic [WIDTH-1:0] dout;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Hand-derived expectations for the registered build, starting from reset.
    tbl[0]  = '{0, 0, 1, 0, 64'hA1, 1, 0, 0, 0, 64'h0};
    tbl[1]  = '{0, 0, 1, 0, 64'hA2, 2, 0, 0, 0, 64'h0};
    tbl[2]  = '{0, 0, 1, 0, 64'hA3, 3, 0, 0, 0, 64'h0};
    tbl[3]  = '{0, 0, 1, 0, 64'hA4, 4, 0, 0, 0, 64'h0};
    tbl[4]  = '{0, 0, 1, 0, 64'hA5, 5, 0, 0, 0, 64'h0};
    tbl[5]  = '{0, 0, 1, 0, 64'hFF, 5, 1, 0, 0, 64'h0};   // write while full dropped
    tbl[6]  = '{0, 0, 0, 1, 64'h0,  4, 1, 0, 1, 64'hA1};
    tbl[7]  = '{0, 1, 0, 0, 64'h0,  4, 0, 0, 0, 64'hA1};  // clear, data held
    tbl[8]  = '{0, 0, 1, 1, 64'hB1, 4, 0, 0, 1, 64'hA2};
    tbl[9]  = '{0, 0, 0, 1, 64'h0,  3, 0, 0, 1, 64'hA3};
    tbl[10] = '{1, 0, 1, 1, 64'hEE, 0, 0, 0, 0, 64'hA3};  // flush masks requests
    tbl[11] = '{0, 0, 0, 1, 64'h0,  0, 0, 1, 0, 64'hA3};  // read on empty
    tbl[12] = '{0, 1, 1, 0, 64'hC1, 1, 0, 0, 0, 64'hA3};
    tbl[13] = '{0, 0, 0, 1, 64'h0,  0, 0, 0, 1, 64'hC1};
    tbl[14] = '{0, 1, 0, 1, 64'h0,  0, 0, 1, 0, 64'hC1};  // clear loses to new error

    @(negedge clock);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].fl, tbl[i].cl, tbl[i].wr, tbl[i].rd, tbl[i].din);
      check_level($sformatf("tbl%0d", i), tbl[i].cnt);
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d.udf", i), 64'(underflow), 64'(tbl[i].udf));
`ifndef PARAM_SYNCH_FIFO_FWFT_EN
      chk($sformatf("tbl%0d.vld", i), 64'(dout_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d.dout", i), data_out, tbl[i].dout);
`endif
    end

    // Sustained simultaneous read/write at count 2: pointers wrap repeatedly.
    do_reset();
    drive(0, 0, 1, 0, 64'h100);
    drive(0, 0, 1, 0, 64'h101);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1, 64'h102 + 64'(i));
      check_model($sformatf("wrap%0d", i));
    end

    // Flush at count 3 with an error pending leaves the error flag intact.
    do_reset();
    drive(0, 0, 0, 1, 64'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 64'h200 + 64'(i));
    check_model("preflush");
    drive(1, 0, 0, 0, 64'h0);
    check_model("flush");

    // FWFT build: first word appears without a read request.
    do_reset();
    drive(0, 0, 1, 0, 64'h3C);
    check_model("fwft_first");

    // Asynchronous reset in the middle of a burst.
    drive(0, 0, 1, 0, 64'h3D);
    drive(0, 0, 1, 1, 64'h3E);
    write_en = 1'b1; read_en = 1'b1; data_in = 64'h3F;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(negedge clock);
    check_reset_values("heldreset");
    write_en = 1'b0; read_en = 1'b0;
    reset_n = 1'b1;

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
            {$urandom, $urandom});
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_synch_fifo.md
# param_synch_fifo

Parametrised single-clock FIFO for the packet datapath pcores. It buffers WIDTH-bit words in register storage of arbitrary (non-power-of-two) DEPTH. It adds programmable almost-full/almost-empty thresholds, an exported fill level, sticky overflow/underflow error flags and a synchronous flush. A compile-time option selects first-word-fall-through (FWFT) output instead of the registered read-request output.

## Interface
- WIDTH, 64: data word width in bits.
- DEPTH, 5: number of storage entries, ≥2, any integer.
- AFULL_THRESH, DEPTH-1: almost_full asserts when fill_count ≥ this value.
- AEMPTY_THRESH, 1: almost_empty asserts when fill_count ≤ this value.
- CNT_W, clog2(DEPTH+1): derived localparam; width of fill_count.

- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents; highest priority.
- clear_errors  in  1  synchronous clear of overflow/underflow.
- data_in  in  WIDTH  write data.
- write_en  in  1  write request.
- read_en  in  1  read request (standard) / pop acknowledge (FWFT).
- data_out  out  WIDTH  read data.
- dout_valid  out  1  data_out holds a valid word.
- fill_count  out  CNT_W  number of stored words, 0..DEPTH.
- empty, full, almost_empty, almost_full  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Write accepted: write_en && !full. Read accepted: read_en && !empty. Acceptance is decided on the state at the start of the cycle.
- A write to a full FIFO is dropped; storage, pointers and count are unchanged; overflow sets.
- A read of an empty FIFO changes no state; underflow sets.
- Simultaneous accepted read and write leave fill_count unchanged and advance both pointers.
- At full with both requests, only the read is accepted; overflow sets.
- Pointers write_addr and read_addr run 0..DEPTH-1 and wrap to 0 after DEPTH-1, with no power-of-two assumption.
- fill_count moves +1 on write only, −1 on read only, and is otherwise held. It never leaves 0..DEPTH.
- Flags are combinational from the registered fill_count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (count ≥ AFULL_THRESH)
  - almost_empty = (count ≤ AEMPTY_THRESH)
- overflow and underflow are sticky until clear_errors or reset. If clear_errors and a new error occur in the same cycle, the flag stays set.
- flush zeroes the pointers and fill_count and clears dout_valid. It ignores write_en and read_en that cycle, does not alter the error flags, and holds data_out in standard mode.
- Reset (asynchronous, any time, including mid-burst) zeroes pointers, count, data_out, dout_valid, overflow and underflow. Storage contents need not be reset.
- Reset values: empty=1, full=0, almost_empty=1 when AEMPTY_THRESH≥0, almost_full=0, fill_count=0, data_out=0, dout_valid=0.

## Timing
- Standard mode: on a read accepted in cycle N, data_out is registered with storage[read_addr] and dout_valid=1 in cycle N+1. dout_valid is 0 in cycle N+1 if no read was accepted in cycle N.
- Write in cycle N is visible in fill_count and the flags in cycle N+1. The earliest read of that word is accepted in cycle N+1, with data in N+2.
- In standard mode, data_out holds its last value between reads.
- FWFT mode: data_out = storage[read_addr] and dout_valid = !empty, both combinational. A write into an empty FIFO in cycle N presents the word in cycle N+1. read_en with dout_valid=1 pops the word, and the next word (if any) appears in the following cycle.

## Configuration
- PARAM_SYNCH_FIFO_FWFT_EN defined: FWFT output as above. No data_out register exists; data_out resets to storage contents, and dout_valid=0 in reset.
- Undefined: standard registered read-request output with 1-cycle read latency.
- All other behaviour is identical in both modes.

## Test plan
- DEPTH=5, reset, write 5 words 0xA1..0xA5, read 5 (standard) -> data_out sequence 0xA1..0xA5 each one cycle after read_en. fill_count steps 5→0, and empty returns to 1 on the cycle after the last read.
- DEPTH=5, fill 5, write 0xFF while full -> fill_count stays 5, overflow=1. Subsequent reads return only the original 5 words. clear_errors -> overflow=0 on the next cycle.
- Read on empty -> underflow=1, dout_valid stays 0, fill_count stays 0.
- Hold write_en and read_en for 20 cycles from count 2 -> count stays 2, pointers wrap past 4→0, and output order matches input order.
- AFULL_THRESH=4, AEMPTY_THRESH=1: count 1 -> almost_empty=1; count 4 -> almost_full=1; count 2 -> both 0. Then flush at count 3 -> count 0, empty=1 next cycle, error flags unchanged.
- PARAM_SYNCH_FIFO_FWFT_EN: write 0x3C into empty -> dout_valid=1, data_out=0x3C next cycle without read_en. Assert reset_n low mid-burst -> all outputs take reset values immediately.
